// File: rtl/mem_port_arbiter_if.sv
// Bundles the core, OCD and RAM-side signals of the data RAM port arbiter.
// slave is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   // core load/store/fetch port
   logic                  core_req;
   logic [ADDR_WIDTH-1:0] core_addr;
   logic [BE_WIDTH-1:0]   core_we;
   logic [DATA_WIDTH-1:0] core_wdata;
   logic                  core_gnt;
   logic                  core_rvalid;
   logic [DATA_WIDTH-1:0] core_rdata;

   // on-chip debugger port
   logic                  ocd_req;
   logic                  ocd_lock;
   logic [ADDR_WIDTH-1:0] ocd_addr;
   logic                  ocd_we;
   logic [DATA_WIDTH-1:0] ocd_wdata;
   logic                  ocd_gnt;
   logic                  ocd_rvalid;
   logic [DATA_WIDTH-1:0] ocd_rdata;

   // RAM side
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [BE_WIDTH-1:0]   mem_write_en;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic [DATA_WIDTH-1:0] mem_read_data;

   modport slave (
      input  core_req, core_addr, core_we, core_wdata,
      output core_gnt, core_rvalid, core_rdata,
      input  ocd_req, ocd_lock, ocd_addr, ocd_we, ocd_wdata,
      output ocd_gnt, ocd_rvalid, ocd_rdata,
      output mem_addr, mem_write_en, mem_write_data,
      input  mem_read_data
   );

   modport master (
      output core_req, core_addr, core_we, core_wdata,
      input  core_gnt, core_rvalid, core_rdata,
      output ocd_req, ocd_lock, ocd_addr, ocd_we, ocd_wdata,
      input  ocd_gnt, ocd_rvalid, ocd_rdata,
      input  mem_addr, mem_write_en, mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data RAM between the core and the on-chip debugger.
// Core has fixed priority; a starvation counter forces an OCD grant after
// OCD_MAX_WAIT refusals, and OCD may lock the port for burst transfers.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int OCD_MAX_WAIT = 8
) (
   input logic               clk,
   input logic               reset_n,
   input logic               sync_reset,
   mem_port_arbiter_if.slave bus
);
   localparam int         BE_WIDTH = DATA_WIDTH / 8;
   localparam logic [7:0] WAIT_MAX = 8'(OCD_MAX_WAIT - 1);

   typedef enum logic [1:0] {
      CORE_PRI,
      OCD_FORCE,
      OCD_LOCK
   } arb_state_t;

   arb_state_t            state;
   logic                  arb_en;
   logic [7:0]            wait_cnt;
   logic                  rvalid_core;
   logic                  rvalid_ocd;
   logic [ADDR_WIDTH-1:0] addr_hold;

   logic                  ocd_first;
   logic                  core_win;
   logic                  ocd_win;
   logic                  grant_ok;
   logic                  core_gnt;
   logic                  ocd_gnt;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [BE_WIDTH-1:0]   mem_we_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;

   // Pick a winner for this cycle; grants are combinational, zero latency.
   // A lock only outranks the core while OCD keeps both lock and request up,
   // so the cycle lock drops falls back to normal core priority.
   always_comb begin
      ocd_first = (state == OCD_FORCE) || ((state == OCD_LOCK) && bus.ocd_lock);
      core_win  = bus.core_req && !(ocd_first && bus.ocd_req);
      ocd_win   = bus.ocd_req && !core_win;
      grant_ok  = arb_en && !sync_reset;
      core_gnt  = grant_ok && core_win;
      ocd_gnt   = grant_ok && ocd_win;
   end

   // Route the granted requester to the RAM; park the address when idle.
   always_comb begin
      mem_addr_c  = addr_hold;
      mem_we_c    = '0;
      mem_wdata_c = '0;
      if (core_gnt) begin
         mem_addr_c  = bus.core_addr;
         mem_we_c    = bus.core_we;
         mem_wdata_c = bus.core_wdata;
      end else if (ocd_gnt) begin
         mem_addr_c  = bus.ocd_addr;
         mem_we_c    = {BE_WIDTH{bus.ocd_we}};
         mem_wdata_c = bus.ocd_wdata;
      end
   end

   // Arbiter state, starvation counter, read-valid pipeline and address hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arb_en      <= 1'b0;
         state       <= CORE_PRI;
         wait_cnt    <= '0;
         rvalid_core <= 1'b0;
         rvalid_ocd  <= 1'b0;
         addr_hold   <= '0;
      end else if (sync_reset) begin
         arb_en      <= 1'b0;
         state       <= CORE_PRI;
         wait_cnt    <= '0;
         rvalid_core <= 1'b0;
         rvalid_ocd  <= 1'b0;
         addr_hold   <= '0;
      end else begin
         arb_en      <= 1'b1;
         rvalid_core <= core_gnt && (bus.core_we == '0);
         rvalid_ocd  <= ocd_gnt && !bus.ocd_we;

         if (core_gnt || ocd_gnt) begin
            addr_hold <= mem_addr_c;
         end

         if (!bus.ocd_req || ocd_gnt) begin
            wait_cnt <= '0;
         end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 8'd1;
         end

         // Starvation is checked before the lock fallback so a refused OCD
         // that has waited long enough is forced even out of OCD_LOCK.
         if (!bus.ocd_req) begin
            state <= CORE_PRI;
         end else if (ocd_gnt) begin
            state <= bus.ocd_lock ? OCD_LOCK : CORE_PRI;
         end else if (wait_cnt == WAIT_MAX) begin
            state <= OCD_FORCE;
         end else if (state == OCD_LOCK) begin
            state <= CORE_PRI;
         end
      end
   end

   assign bus.core_gnt       = core_gnt;
   assign bus.ocd_gnt        = ocd_gnt;
   assign bus.core_rvalid    = rvalid_core && !sync_reset;
   assign bus.ocd_rvalid     = rvalid_ocd && !sync_reset;
   assign bus.core_rdata     = bus.mem_read_data;
   assign bus.ocd_rdata      = bus.mem_read_data;
   assign bus.mem_addr       = mem_addr_c;
   assign bus.mem_write_en   = mem_we_c;
   assign bus.mem_write_data = mem_wdata_c;
endmodule
